// File: rtl/hdr_pulse_gen_pkg.sv
// hdr_pulse_gen_pkg: shared FSM state type, mode/trigger encodings and default counter width
package hdr_pulse_gen_pkg;
   typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;
   localparam logic MODE_SINGLE   = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;
   localparam logic TRIG_SW       = 1'b0;
   localparam logic TRIG_EXT      = 1'b1;
   localparam int   CNT_W_DEF     = 16;
endpackage

// File: rtl/hdr_pulse_gen_if.sv
// hdr_pulse_gen_if: configuration/status bundle of hdr_pulse_gen
//   master -> slave : en, mode, trig_sel, sw_start, ext_trig, period, delay, width, invert
//   slave -> master : pulse_out, frame_start, busy, frame_cnt
//   HDR_PULSE_GEN_BURST_EN adds burst_len (master -> slave) and burst_done (slave -> master)
interface hdr_pulse_gen_if import hdr_pulse_gen_pkg::*; #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = CNT_W_DEF
);
   logic                    en, mode, trig_sel, sw_start, ext_trig;
   logic [CNT_W-1:0]        period;
   logic [NUM_CH*CNT_W-1:0] delay, width;
   logic [NUM_CH-1:0]       invert, pulse_out;
   logic                    frame_start, busy;
   logic [31:0]             frame_cnt;
`ifdef HDR_PULSE_GEN_BURST_EN
   logic [15:0]             burst_len;
   logic                    burst_done;
   modport master (output en, mode, trig_sel, sw_start, ext_trig, period, delay, width, invert, burst_len,
                   input  pulse_out, frame_start, busy, frame_cnt, burst_done);
   modport slave  (input  en, mode, trig_sel, sw_start, ext_trig, period, delay, width, invert, burst_len,
                   output pulse_out, frame_start, busy, frame_cnt, burst_done);
`else
   modport master (output en, mode, trig_sel, sw_start, ext_trig, period, delay, width, invert,
                   input  pulse_out, frame_start, busy, frame_cnt);
   modport slave  (input  en, mode, trig_sel, sw_start, ext_trig, period, delay, width, invert,
                   output pulse_out, frame_start, busy, frame_cnt);
`endif
endinterface

// File: rtl/hdr_pulse_ch.sv
// hdr_pulse_ch: one pulse channel - frame-start shadow registers, overflow-safe window compare, output flop
//   clk, resetn          : clock, asynchronous active-low reset
//   load                 : frame start; captures delay/width/invert for the coming frame
//   run                  : FSM is in RUN; otherwise the output idles at the live invert level
//   fc                   : frame counter
//   delay, width, invert : live channel settings
//   pulse_out            : registered channel output, one cycle behind fc
module hdr_pulse_ch import hdr_pulse_gen_pkg::*; #(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             load,
   input  logic             run,
   input  logic [CNT_W-1:0] fc,
   input  logic [CNT_W-1:0] delay,
   input  logic [CNT_W-1:0] width,
   input  logic             invert,
   output logic             pulse_out
);
   logic [CNT_W-1:0] d_sh, w_sh;
   logic             i_sh, act;
   logic [CNT_W:0]   ofs;
   // one extra bit so a window near the top of the counter range never wraps
   always_comb begin
      ofs = {1'b0, fc} - {1'b0, d_sh};
      act = (fc >= d_sh) && (ofs < {1'b0, w_sh});
   end
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         d_sh      <= '0;
         w_sh      <= '0;
         i_sh      <= 1'b0;
         pulse_out <= 1'b0;
      end else begin
         if (load) begin
            d_sh <= delay;
            w_sh <= width;
            i_sh <= invert;
         end
         pulse_out <= run ? act ^ i_sh : invert;
      end
endmodule

// File: rtl/hdr_pulse_gen.sv
// hdr_pulse_gen: multi-channel frame-referenced pulse generator (single-shot / periodic, sw or ext trigger)
//   clk, resetn : clock, asynchronous active-low reset
//   bus (slave) : config in (en, mode, trig_sel, sw_start, ext_trig, period, delay, width, invert),
//                 status out (pulse_out, frame_start, busy, frame_cnt)
//   HDR_PULSE_GEN_BURST_EN : adds bus.burst_len / bus.burst_done, periodic bursts of burst_len frames
module hdr_pulse_gen import hdr_pulse_gen_pkg::*; #(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = CNT_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input logic            clk,
   input logic            resetn,
   hdr_pulse_gen_if.slave bus
);
   state_t                 state, state_nx;
   logic [SYNC_STAGES-1:0] sync;
   logic                   sync_q, ext_rise, run, trig, last, ok, start, burst_stop;
   logic [CNT_W-1:0]       fc, per_sh;
   logic [NUM_CH-1:0]      po;
`ifdef HDR_PULSE_GEN_BURST_EN
   logic [15:0]            bcnt;
`endif
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         sync     <= '0;
         sync_q   <= 1'b0;
         ext_rise <= 1'b0;
      end else begin
         sync     <= {sync[SYNC_STAGES-2:0], bus.ext_trig};
         sync_q   <= sync[SYNC_STAGES-1];
         ext_rise <= sync[SYNC_STAGES-1] & ~sync_q;
      end
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) state <= IDLE;
      else         state <= state_nx;
   always_comb
      state_nx = start            ? RUN :
                 state == IDLE    ? (ok ? ARMED : IDLE) :
                 state == ARMED   ? (ok ? ARMED : IDLE) :
                 last             ? ((bus.mode == MODE_SINGLE || burst_stop) ? ARMED : IDLE) : RUN;
   // a new frame needs a usable period; back-to-back frames start on the last cycle of the previous one
   always_comb begin
      run  = state == RUN;
      trig = bus.trig_sel == TRIG_SW ? bus.sw_start : ext_rise;
      last = run && fc == per_sh - CNT_W'(1);
      ok   = bus.en && bus.period != '0;
`ifdef HDR_PULSE_GEN_BURST_EN
      burst_stop = bus.burst_len != 16'd0 && bcnt == bus.burst_len;
`else
      burst_stop = 1'b0;
`endif
      start = ok && (state == ARMED ? trig : last && bus.mode == MODE_PERIODIC && !burst_stop);
   end
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         fc              <= '0;
         per_sh          <= '0;
         bus.frame_start <= 1'b0;
         bus.frame_cnt   <= '0;
      end else begin
         fc              <= start ? '0 : (run && !last) ? fc + CNT_W'(1) : fc;
         bus.frame_start <= start;
         if (start) begin
            per_sh        <= bus.period;
            bus.frame_cnt <= bus.frame_cnt + 32'd1;
         end
      end
`ifdef HDR_PULSE_GEN_BURST_EN
   always_ff @(posedge clk or negedge resetn)
      if (!resetn)    bcnt <= '0;
      else if (start) bcnt <= state == ARMED ? 16'd1 : bcnt + 16'd1;
   assign bus.burst_done = last && bus.mode == MODE_PERIODIC && burst_stop;
`endif
   assign bus.busy      = run;
   assign bus.pulse_out = po;
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      hdr_pulse_ch #(.CNT_W(CNT_W)) u_ch (
         .clk       (clk),
         .resetn    (resetn),
         .load      (start),
         .run       (run),
         .fc        (fc),
         .delay     (bus.delay[i*CNT_W +: CNT_W]),
         .width     (bus.width[i*CNT_W +: CNT_W]),
         .invert    (bus.invert[i]),
         .pulse_out (po[i])
      );
   end
endmodule

// File: tb/tb_hdr_pulse_gen.sv
// tb_hdr_pulse_gen: directed and randomized self-check of hdr_pulse_gen against a frame-timestamp model
module tb_hdr_pulse_gen;
   localparam int NCH = 4;
   localparam int CW  = 16;
   localparam int SS  = 2;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;
   hdr_pulse_gen_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();
   hdr_pulse_gen #(.NUM_CH(NCH), .CNT_W(CW), .SYNC_STAGES(SS)) dut (.clk(clk), .resetn(resetn), .bus(bus));
   int passed = 0;
   int total  = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got === want) passed++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, want, cyc);
   endtask
   // Reference model: a frame is a timestamp f0 (cycle of its frame_start); fc in cycle c is c - f0.
   int               ph;
   int               f0, per, mcnt, nb;
   int               md [NCH];
   int               mw [NCH];
   logic [NCH-1:0]   mi, m_po;
   logic             m_fs;
   logic [SS+2:0]    hist;
   always @(posedge clk or negedge resetn) begin
      int   p, fc;
      logic tr, lst, okp, st, bstop;
      if (!resetn) begin
         ph = 0; f0 = 0; per = 0; mcnt = 0; nb = 0;
         mi = '0; m_po = '0; m_fs = 1'b0; hist = '0;
         for (int i = 0; i < NCH; i++) begin md[i] = 0; mw[i] = 0; end
      end else begin
         p  = cyc;
         fc = p - f0;
         for (int i = 0; i < NCH; i++)
            m_po[i] = (ph == 2) ? ((fc >= md[i] && fc < md[i] + mw[i]) ^ mi[i]) : bus.invert[i];
         hist = {hist[SS+1:0], bus.ext_trig};
         tr   = bus.trig_sel ? (hist[SS+1] & ~hist[SS+2]) : bus.sw_start;
         lst  = ph == 2 && fc == per - 1;
         okp  = bus.en && bus.period != 0;
`ifdef HDR_PULSE_GEN_BURST_EN
         bstop = bus.burst_len != 0 && nb == int'(bus.burst_len);
`else
         bstop = 1'b0;
`endif
         st = okp && (ph == 1 ? tr : (lst && bus.mode && !bstop));
         if (st) begin
            nb  = (ph == 2) ? nb + 1 : 1;
            ph  = 2;
            f0  = p + 1;
            per = int'(bus.period);
            mi  = bus.invert;
            for (int i = 0; i < NCH; i++) begin
               md[i] = int'(bus.delay[i*CW +: CW]);
               mw[i] = int'(bus.width[i*CW +: CW]);
            end
            mcnt++;
         end else if (ph == 0 && okp) ph = 1;
         else if (ph == 1 && !okp) ph = 0;
         else if (lst) ph = (!bus.mode || bstop) ? 1 : 0;
         m_fs = st;
      end
   end
   always @(negedge clk) begin
      #1;
      chk("pulse_out", 32'(bus.pulse_out), 32'(m_po));
      chk("frame_start", 32'(bus.frame_start), 32'(m_fs));
      chk("busy", 32'(bus.busy), 32'(ph == 2));
      chk("frame_cnt", bus.frame_cnt, mcnt);
`ifdef HDR_PULSE_GEN_BURST_EN
      chk("burst_done", 32'(bus.burst_done),
          32'(ph == 2 && cyc - f0 == per - 1 && bus.mode && bus.burst_len != 0 && nb == int'(bus.burst_len)));
`endif
   end
   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic set_ch(input int i, input int d, input int w, input logic inv);
      bus.delay[i*CW +: CW] = CW'(d);
      bus.width[i*CW +: CW] = CW'(w);
      bus.invert[i]         = inv;
   endtask
   task automatic clear();
      bus.en = 0; bus.mode = 0; bus.trig_sel = 0; bus.sw_start = 0; bus.ext_trig = 0;
      bus.period = '0; bus.delay = '0; bus.width = '0; bus.invert = '0;
`ifdef HDR_PULSE_GEN_BURST_EN
      bus.burst_len = '0;
`endif
   endtask
   task automatic do_reset();
      clear();
      resetn = 1'b0;
      cycles(2);
      resetn = 1'b1;
      cycles(1);
   endtask
   int c0, hi0, first0, hi1, hi2, lo3;
   initial begin
      clear();
      cycles(2);
      chk("rst_pulse_out", 32'(bus.pulse_out), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_frame_cnt", bus.frame_cnt, 0);
      chk("rst_frame_start", 32'(bus.frame_start), 0);
      resetn = 1'b1;
      cycles(1);
      // single-shot, sw trigger
      bus.period = 100; set_ch(0, 0, 1, 0); set_ch(1, 10, 5, 0); bus.en = 1;
      cycles(3);
      bus.sw_start = 1;
      for (int n = 1; n <= 105; n++) begin
         @(negedge clk);
         bus.sw_start = 0;
         chk("ss_ch0", 32'(bus.pulse_out[0]), 32'(n == 2));
         chk("ss_ch1", 32'(bus.pulse_out[1]), 32'(n >= 12 && n <= 16));
         chk("ss_busy", 32'(bus.busy), 32'(n <= 100));
         chk("ss_frame_start", 32'(bus.frame_start), 32'(n == 1));
      end
      chk("ss_frame_cnt", bus.frame_cnt, 1);
      // periodic, en dropped at fc = 3 of the second frame
      bus.mode = 1; bus.period = 8;
      for (int i = 0; i < NCH; i++) set_ch(i, $urandom_range(0, 9), $urandom_range(0, 9), 1'($urandom_range(0, 1)));
      c0 = bus.frame_cnt;
      bus.sw_start = 1;
      for (int n = 1; n <= 24; n++) begin
         @(negedge clk);
         bus.sw_start = 0;
         if (n == 12) bus.en = 0;
         chk("per_frame_start", 32'(bus.frame_start), 32'(n == 1 || n == 9));
         chk("per_busy", 32'(bus.busy), 32'(n <= 16));
      end
      chk("per_frame_cnt", bus.frame_cnt, c0 + 2);
      // ext trigger, second edge inside RUN ignored
      bus.mode = 0; bus.trig_sel = 1; bus.period = 20; bus.en = 1;
      cycles(3);
      c0 = bus.frame_cnt;
      bus.ext_trig = 1;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         if (n == 8) bus.ext_trig = 0;
         if (n == 10) bus.ext_trig = 1;
         chk("ext_frame_start", 32'(bus.frame_start), 32'(n == 4));
         chk("ext_busy", 32'(bus.busy), 32'(n >= 4 && n <= 23));
      end
      chk("ext_frame_cnt", bus.frame_cnt, c0 + 1);
      bus.ext_trig = 0; bus.trig_sel = 0;
      cycles(4);
      // boundaries: top-of-range window, width 0, delay = period, inverted idle
      bus.period = 16'hFFFF;
      set_ch(0, 16'hFFF0, 16'h0020, 0); set_ch(1, 3, 0, 0); set_ch(2, 16'hFFFF, 5, 0); set_ch(3, 0, 0, 1);
      cycles(3);
      chk("inv_idle_high", 32'(bus.pulse_out[3]), 1);
      bus.sw_start = 1;
      hi0 = 0; first0 = -1; hi1 = 0; hi2 = 0; lo3 = 0;
      for (int n = 1; n <= 65540; n++) begin
         @(negedge clk);
         bus.sw_start = 0;
         if (bus.pulse_out[0]) begin hi0++; if (first0 < 0) first0 = n; end
         if (bus.pulse_out[1]) hi1++;
         if (bus.pulse_out[2]) hi2++;
         if (!bus.pulse_out[3]) lo3++;
      end
      chk("bnd_ch0_len", hi0, 15);
      chk("bnd_ch0_first", first0, 2 + 16'hFFF0);
      chk("bnd_width0", hi1, 0);
      chk("bnd_delay_eq_period", hi2, 0);
      chk("bnd_inverted", lo3, 0);
      // shadowing: ch0 delay 5 -> 20 at fc = 2
      bus.mode = 1; bus.period = 30; set_ch(0, 5, 1, 0); set_ch(3, 0, 0, 0);
      cycles(2);
      bus.sw_start = 1;
      for (int n = 1; n <= 58; n++) begin
         @(negedge clk);
         bus.sw_start = 0;
         if (n == 3) set_ch(0, 20, 1, 0);
         chk("shadow_ch0", 32'(bus.pulse_out[0]), 32'(n == 7 || n == 52));
      end
      bus.en = 0;
      cycles(10);
      // async reset at fc = 50
      bus.mode = 0; bus.period = 100; bus.en = 1; bus.invert = 4'b1010;
      cycles(3);
      bus.sw_start = 1;
      for (int n = 1; n <= 51; n++) begin
         @(negedge clk);
         bus.sw_start = 0;
      end
      chk("pre_rst_busy", 32'(bus.busy), 1);
      #2 resetn = 1'b0;
      #1;
      chk("arst_pulse_out", 32'(bus.pulse_out), 0);
      chk("arst_busy", 32'(bus.busy), 0);
      chk("arst_frame_cnt", bus.frame_cnt, 0);
      chk("arst_frame_start", 32'(bus.frame_start), 0);
      @(negedge clk);
      clear();
      resetn = 1'b1;
      cycles(2);
`ifdef HDR_PULSE_GEN_BURST_EN
      bus.burst_len = 3; bus.mode = 1; bus.period = 5; bus.en = 1;
      cycles(3);
      bus.sw_start = 1;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         bus.sw_start = 0;
         chk("burst_frame_start", 32'(bus.frame_start), 32'(n == 1 || n == 6 || n == 11));
         chk("burst_done_lit", 32'(bus.burst_done), 32'(n == 15));
         chk("burst_busy", 32'(bus.busy), 32'(n <= 15));
      end
      bus.sw_start = 1;
      @(negedge clk);
      bus.sw_start = 0;
      chk("burst_rearmed", 32'(bus.frame_start), 1);
      do_reset();
`endif
      // randomized traffic
      do_reset();
      bus.en = 1; bus.period = 6;
      for (int n = 0; n < 4000; n++) begin
         @(negedge clk);
         bus.sw_start = $urandom_range(0, 12) == 0;
         if ($urandom_range(0, 5) == 0) bus.ext_trig = ~bus.ext_trig;
         if ($urandom_range(0, 40) == 0) bus.en = ~bus.en;
         if ($urandom_range(0, 80) == 0) bus.mode = ~bus.mode;
         if ($urandom_range(0, 80) == 0) bus.trig_sel = ~bus.trig_sel;
         if ($urandom_range(0, 50) == 0) bus.period = CW'($urandom_range(0, 12));
         if ($urandom_range(0, 15) == 0)
            set_ch($urandom_range(0, NCH - 1), $urandom_range(0, 14), $urandom_range(0, 8), 1'($urandom_range(0, 1)));
`ifdef HDR_PULSE_GEN_BURST_EN
         if ($urandom_range(0, 100) == 0) bus.burst_len = 16'($urandom_range(0, 4));
`endif
      end
      cycles(2);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
